ysyx_23060124_seq_ctrl: RTL and testbench

//  Multi-cycle instruction sequencer for the single-issue core. Drives fetch request,

---
 rtl/ysyx_23060124_seq_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_23060124_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_23060124_seq_ctrl
//
// Multi-cycle instruction sequencer for the single-issue core. Steps one
// instruction at a time through FETCH -> DECODE -> [MEM] -> WB and drives:
//   - the fetch request and the instruction-register load strobe
//   - the load/store unit request
//   - the register-file write strobe and the PC update strobe
// It stops in HALT on ebreak and in ERROR on a decode error, on a load that is
// also marked as a store, or on a handshake timeout.
//
// Parameters
//   WAIT_W   width of the handshake wait counter
//   TIMEOUT  max cycles spent in FETCH or MEM before ERROR (< 2**WAIT_W)
//
// Ports
//   i_clk         core clock
//   i_rst         synchronous reset, active-high
//   o_ifu_req     fetch request, high for the whole of FETCH
//   i_ifu_valid   fetched instruction valid (1-cycle pulse)
//   o_ins_latch   load the instruction register this cycle
//   i_dec_load    decoded instruction is a load
//   i_dec_store   decoded instruction is a store
//   i_dec_wen     decoded instruction writes rd
//   i_dec_ebreak  decoded instruction is ebreak
//   i_dec_err     decoder flagged an illegal encoding
//   o_lsu_req     LSU request, high for the whole of MEM
//   i_lsu_done    LSU access complete (1-cycle pulse)
//   o_rf_wen      register-file write strobe (1 cycle, WB only)
//   o_pc_upd      PC update strobe (1 cycle, WB only)
//   o_halt        sticky: ebreak retired
//   o_err         sticky: decode error, load&store, or timeout
//   o_state       current state encoding (debug)
//   o_cyc_cnt     [YSYX_23060124_PERF_CNT_EN only] running cycles outside HALT/ERROR
//   o_ins_cnt     [YSYX_23060124_PERF_CNT_EN only] retired instructions (WB count)
//
// Build option
//   YSYX_23060124_PERF_CNT_EN  adds the two 64-bit performance counters.
//
// States
//   state  | code | meaning
//   IDLE   |  0   | out of reset, starts fetching next cycle
//   FETCH  |  1   | fetch request held until the instruction arrives
//   DECODE |  2   | decoder outputs sampled, instruction class chosen
//   MEM    |  3   | LSU request held until the access completes
//   WB     |  4   | register write-back and PC update, one cycle
//   HALT   |  5   | ebreak retired, parked until reset
//   ERROR  |  6   | fault detected, parked until reset
// ----------------------------------------------------------------------------
module ysyx_23060124_seq_ctrl #(
    parameter int WAIT_W  = 8,
    parameter int TIMEOUT = 200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_ifu_req,
    input  logic        i_ifu_valid,
    output logic        o_ins_latch,
    input  logic        i_dec_load,
    input  logic        i_dec_store,
    input  logic        i_dec_wen,
    input  logic        i_dec_ebreak,
    input  logic        i_dec_err,
    output logic        o_lsu_req,
    input  logic        i_lsu_done,
    output logic        o_rf_wen,
    output logic        o_pc_upd,
    output logic        o_halt,
    output logic        o_err,
    output logic [2:0]  o_state
`ifdef YSYX_23060124_PERF_CNT_EN
    ,
    output logic [63:0] o_cyc_cnt,
    output logic [63:0] o_ins_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic                w_wait_tc;
    logic                r_wb_wen;
    logic                w_wb_wen_nxt;

    logic                r_ifu_req;
    logic                r_lsu_req;
    logic                r_rf_wen;
    logic                r_pc_upd;
    logic                r_halt;
    logic                r_err;

    // Last pending cycle: the counter holds the number of cycles already
    // spent waiting, so TIMEOUT-1 marks the TIMEOUT-th cycle of the state.
    assign w_wait_tc = (r_wait == WAIT_W'(TIMEOUT - 1));

    // Write enable for WB is captured in DECODE, where the decoder outputs
    // are defined to be valid; MEM -> WB reuses the captured value.
    assign w_wb_wen_nxt = (r_state == S_DECODE) ? (i_dec_wen & ~i_dec_store)
                                                : r_wb_wen;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                // A handshake arriving on the timeout cycle still wins.
                if (i_ifu_valid) begin
                    w_next = S_DECODE;
                end else if (w_wait_tc) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                if (i_dec_err || (i_dec_load && i_dec_store)) begin
                    w_next = S_ERROR;
                end else if (i_dec_ebreak) begin
                    w_next = S_HALT;
                end else if (i_dec_load || i_dec_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (i_lsu_done) begin
                    w_next = S_WB;
                end else if (w_wait_tc) begin
                    w_next = S_ERROR;
                end
            end
            S_WB: begin
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            S_ERROR: begin
                w_next = S_ERROR;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, wait counter and the state-decoded outputs all update together,
    // so every output is a flop that tracks the state register exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_wb_wen  <= 1'b0;
            r_ifu_req <= 1'b0;
            r_lsu_req <= 1'b0;
            r_rf_wen  <= 1'b0;
            r_pc_upd  <= 1'b0;
            r_halt    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wb_wen <= w_wb_wen_nxt;

            if (w_next != r_state) begin
                r_wait <= '0;
            end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end

            r_ifu_req <= (w_next == S_FETCH);
            r_lsu_req <= (w_next == S_MEM);
            r_pc_upd  <= (w_next == S_WB);
            r_rf_wen  <= (w_next == S_WB) & w_wb_wen_nxt;
            r_halt    <= (w_next == S_HALT);
            r_err     <= (w_next == S_ERROR);
        end
    end

    assign o_ifu_req   = r_ifu_req;
    assign o_ins_latch = r_ifu_req & i_ifu_valid;
    assign o_lsu_req   = r_lsu_req;
    assign o_rf_wen    = r_rf_wen;
    assign o_pc_upd    = r_pc_upd;
    assign o_halt      = r_halt;
    assign o_err       = r_err;
    assign o_state     = r_state;

`ifdef YSYX_23060124_PERF_CNT_EN
    logic [63:0] r_cyc_cnt;
    logic [63:0] r_ins_cnt;

    // Cycle counter stops once the core is parked; both wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else begin
            if ((r_state != S_HALT) && (r_state != S_ERROR)) begin
                r_cyc_cnt <= r_cyc_cnt + 64'd1;
            end
            if (r_state == S_WB) begin
                r_ins_cnt <= r_ins_cnt + 64'd1;
            end
        end
    end

    assign o_cyc_cnt = r_cyc_cnt;
    assign o_ins_cnt = r_ins_cnt;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_ysyx_23060124_seq_ctrl.sv
module tb_ysyx_23060124_seq_ctrl;

    localparam int TIMEOUT = 200;

    localparam int K_ALU    = 0;
    localparam int K_LOAD   = 1;
    localparam int K_STORE  = 2;
    localparam int K_EBREAK = 3;
    localparam int K_ERR    = 4;
    localparam int K_LDST   = 5;

    // Output vector order: {ifu_req, ins_latch, lsu_req, rf_wen, pc_upd, halt, err}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_IFU  = 7'b1000000;
    localparam logic [6:0] O_LAT  = 7'b0100000;
    localparam logic [6:0] O_LSU  = 7'b0010000;
    localparam logic [6:0] O_RFW  = 7'b0001000;
    localparam logic [6:0] O_PCU  = 7'b0000100;
    localparam logic [6:0] O_HALT = 7'b0000010;
    localparam logic [6:0] O_ERR  = 7'b0000001;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ifu_valid = 1'b0;
    logic        i_dec_load = 1'b0;
    logic        i_dec_store = 1'b0;
    logic        i_dec_wen = 1'b0;
    logic        i_dec_ebreak = 1'b0;
    logic        i_dec_err = 1'b0;
    logic        i_lsu_done = 1'b0;
    logic        o_ifu_req, o_ins_latch, o_lsu_req, o_rf_wen, o_pc_upd, o_halt, o_err;
    logic [2:0]  o_state;
`ifdef YSYX_23060124_PERF_CNT_EN
    logic [63:0] o_cyc_cnt;
    logic [63:0] o_ins_cnt;
`endif

    ysyx_23060124_seq_ctrl #(.WAIT_W(8), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_ifu_req    (o_ifu_req),
        .i_ifu_valid  (i_ifu_valid),
        .o_ins_latch  (o_ins_latch),
        .i_dec_load   (i_dec_load),
        .i_dec_store  (i_dec_store),
        .i_dec_wen    (i_dec_wen),
        .i_dec_ebreak (i_dec_ebreak),
        .i_dec_err    (i_dec_err),
        .o_lsu_req    (o_lsu_req),
        .i_lsu_done   (i_lsu_done),
        .o_rf_wen     (o_rf_wen),
        .o_pc_upd     (o_pc_upd),
        .o_halt       (o_halt),
        .o_err        (o_err),
        .o_state      (o_state)
`ifdef YSYX_23060124_PERF_CNT_EN
        ,
        .o_cyc_cnt    (o_cyc_cnt),
        .o_ins_cnt    (o_ins_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit         probe;
        logic [2:0] st;
        logic [6:0] outs;
        int         dwell;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    int   probe_req = 0;
    int   ev_idx = 0;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_tr(input logic [2:0] st, input logic [6:0] outs, input int dwell);
        exp_t e;
        e.probe = 1'b0; e.st = st; e.outs = outs; e.dwell = dwell;
        sb_q.push_back(e);
    endtask

    task automatic probe(input logic [2:0] st, input logic [6:0] outs);
        exp_t e;
        e.probe = 1'b1; e.st = st; e.outs = outs; e.dwell = -1;
        sb_q.push_back(e);
        probe_req++;
    endtask

    task automatic sb_check(input bit is_probe, input logic [2:0] st,
                            input logic [6:0] outs, input int dw);
        exp_t       e;
        logic [6:0] mask;
        checks++;
        ev_idx++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected ev%0d: got st=%0d outs=%b, required no event",
                     ev_idx, st, outs);
            return;
        end
        e = sb_q.pop_front();
        // ins_latch depends on the live valid input; transitions check the Moore bits only.
        mask = is_probe ? 7'b1111111 : 7'b1011111;
        if (e.probe != is_probe || e.st !== st || (outs & mask) !== (e.outs & mask) ||
            (!is_probe && e.dwell >= 0 && dw != e.dwell)) begin
            failures++;
            $display("FAIL %s ev%0d: got st=%0d outs=%b dwell=%0d, required st=%0d outs=%b dwell=%0d",
                     is_probe ? "probe" : "trans", ev_idx, st, outs & mask, dw,
                     e.st, e.outs & mask, e.dwell);
        end
    endtask

    // Monitor: pops one expectation per state change (checking the outputs of the
    // new state and how long the old one lasted) and one per probe request.
    initial begin : monitor
        logic [2:0] prev_st;
        logic [2:0] st;
        logic [6:0] outs;
        logic [6:0] inv;
        int         dwell;
        int         probe_seen;
        bit         first;
        prev_st = 3'd0; dwell = 0; probe_seen = 0; first = 1'b1;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                st   = o_state;
                outs = {o_ifu_req, o_ins_latch, o_lsu_req, o_rf_wen, o_pc_upd, o_halt, o_err};
                inv  = {st == 3'd1, (st == 3'd1) && i_ifu_valid, st == 3'd3, 1'b0,
                        st == 3'd4, st == 3'd5, st == 3'd6};
                checks++;
                if ((outs & 7'b1110111) !== inv || (o_rf_wen && st != 3'd4)) begin
                    failures++;
                    $display("FAIL state_outs: st=%0d got outs=%b, required outs=%b (rf_wen only in WB)",
                             st, outs, inv);
                end
                if (first) begin
                    prev_st = st; dwell = 1; first = 1'b0;
                end else if (st != prev_st) begin
                    sb_check(1'b0, st, outs, dwell);
                    prev_st = st; dwell = 1;
                end else begin
                    dwell++;
                end
                if (probe_req != probe_seen) begin
                    probe_seen++;
                    sb_check(1'b1, st, outs, -1);
                end
            end
        end
    end

    // Entry: first FETCH cycle, FETCH entry already expected. Exit: first cycle
    // of the next FETCH (or of HALT/ERROR).
    task automatic run_instr(input int fetch_wait, input int kind, input int mem_wait,
                             input bit wen, input bit spur);
        logic [6:0] wb_outs;
        i_dec_load   = (kind == K_LOAD) || (kind == K_LDST);
        i_dec_store  = (kind == K_STORE) || (kind == K_LDST);
        i_dec_ebreak = (kind == K_EBREAK);
        i_dec_err    = (kind == K_ERR);
        i_dec_wen    = wen;
        wb_outs = O_PCU | ((wen && kind != K_STORE) ? O_RFW : O_NONE);
        for (int i = 0; i < fetch_wait; i++) begin
            i_lsu_done = spur;
            cyc();
        end
        i_lsu_done  = 1'b0;
        i_ifu_valid = 1'b1;
        probe(3'd1, O_IFU | O_LAT);
        push_tr(3'd2, O_NONE, fetch_wait + 1);
        cyc();
        i_ifu_valid = 1'b0;
        if (kind == K_ERR || kind == K_LDST) begin
            push_tr(3'd6, O_ERR, 1);
            cyc();
        end else if (kind == K_EBREAK) begin
            push_tr(3'd5, O_HALT, 1);
            cyc();
        end else if (kind == K_LOAD || kind == K_STORE) begin
            push_tr(3'd3, O_LSU, 1);
            cyc();
            if (mem_wait == 0) begin
                push_tr(3'd6, O_ERR, TIMEOUT);
                repeat (TIMEOUT) cyc();
            end else begin
                repeat (mem_wait - 1) cyc();
                i_lsu_done = 1'b1;
                push_tr(3'd4, wb_outs, mem_wait);
                cyc();
                i_lsu_done = 1'b0;
                push_tr(3'd1, O_IFU, 1);
                cyc();
            end
        end else begin
            push_tr(3'd4, wb_outs, 1);
            cyc();
            push_tr(3'd1, O_IFU, 1);
            cyc();
        end
    endtask

    task automatic do_reset(input int n);
        i_ifu_valid = 1'b0; i_lsu_done = 1'b0;
        i_dec_load = 1'b0; i_dec_store = 1'b0; i_dec_wen = 1'b0;
        i_dec_ebreak = 1'b0; i_dec_err = 1'b0;
        i_rst = 1'b1;
        push_tr(3'd0, O_NONE, -1);
        repeat (n) cyc();
        i_rst = 1'b0;
        push_tr(3'd1, O_IFU, n);
        cyc();
    endtask

    task automatic park_and_probe(input logic [2:0] st, input logic [6:0] outs, input int n);
        for (int i = 0; i < n; i++) begin
            i_ifu_valid = (i % 3 == 0);
            i_lsu_done  = (i % 4 == 1);
            cyc();
        end
        i_ifu_valid = 1'b0;
        i_lsu_done  = 1'b0;
        probe(st, outs);
        cyc();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) cyc();
        mon_en = 1'b1;
        probe(3'd0, O_NONE);
        cyc();
        i_rst = 1'b0;
        push_tr(3'd1, O_IFU, -1);
        cyc();

        // ALU, valid one cycle after request; with and without rd write
        run_instr(1, K_ALU, 0, 1'b1, 1'b0);
        run_instr(1, K_ALU, 0, 1'b0, 1'b0);
        // Load / store with three MEM cycles, then zero-wait load
        run_instr(1, K_LOAD, 3, 1'b1, 1'b0);
        run_instr(1, K_STORE, 3, 1'b1, 1'b0);
        run_instr(0, K_LOAD, 1, 1'b1, 1'b0);
        // Handshakes arriving on the last allowed cycle still proceed
        run_instr(TIMEOUT - 1, K_ALU, 0, 1'b1, 1'b0);
        run_instr(0, K_STORE, TIMEOUT, 1'b0, 1'b0);
        // Spurious lsu_done while fetching is ignored
        run_instr(2, K_ALU, 0, 1'b1, 1'b1);

        // Reset asserted in MEM together with lsu_done: no WB, back to IDLE
        i_dec_load = 1'b1; i_dec_store = 1'b0; i_dec_wen = 1'b1;
        i_dec_ebreak = 1'b0; i_dec_err = 1'b0;
        i_ifu_valid = 1'b1;
        probe(3'd1, O_IFU | O_LAT);
        push_tr(3'd2, O_NONE, 1);
        cyc();
        i_ifu_valid = 1'b0;
        push_tr(3'd3, O_LSU, 1);
        cyc();
        cyc();
        i_rst = 1'b1;
        i_lsu_done = 1'b1;
        push_tr(3'd0, O_NONE, 2);
        cyc();
        i_rst = 1'b0;
        i_lsu_done = 1'b0;
        i_dec_load = 1'b0;
        push_tr(3'd1, O_IFU, 1);
        cyc();
        run_instr(1, K_ALU, 0, 1'b1, 1'b0);

        // ebreak parks in HALT for good
        run_instr(1, K_EBREAK, 0, 1'b0, 1'b0);
        park_and_probe(3'd5, O_HALT, 20);
        do_reset(1);
        // Decode error, then load+store conflict
        run_instr(1, K_ERR, 0, 1'b1, 1'b0);
        park_and_probe(3'd6, O_ERR, 5);
        do_reset(2);
        run_instr(1, K_LDST, 0, 1'b1, 1'b0);
        park_and_probe(3'd6, O_ERR, 5);
        do_reset(1);
        // Fetch never answered
        push_tr(3'd6, O_ERR, TIMEOUT);
        repeat (TIMEOUT) cyc();
        park_and_probe(3'd6, O_ERR, 3);
        do_reset(1);
        // LSU never answers
        run_instr(0, K_LOAD, 0, 1'b1, 1'b0);
        park_and_probe(3'd6, O_ERR, 3);

`ifdef YSYX_23060124_PERF_CNT_EN
        do_reset(3);
        for (int n = 0; n < 10; n++) begin
            run_instr(1, K_ALU, 0, 1'b1, 1'b0);
        end
        checks++;
        if (o_ins_cnt !== 64'd10) begin
            failures++;
            $display("FAIL perf_ins_cnt: got %0d, required 10", o_ins_cnt);
        end
        checks++;
        if (o_cyc_cnt !== 64'd41) begin
            failures++;
            $display("FAIL perf_cyc_cnt: got %0d, required 41", o_cyc_cnt);
        end
`endif

        repeat (4) cyc();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d expected events never seen, required 0",
                     sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
